// File: rtl/pwm_multi.sv
// Multi-channel PWM generator: shared prescaler, double-buffered per-channel period/duty/polarity.
// Latency: pwm_out and period_end update one clk after the prescaler tick that produced them.
// Backpressure: cfg_ready is low only while reset is high; writes to absent channels are dropped.
// Optional feature: define MAWG_PWM_CENTER_EN for center-aligned (triangle) counting.
module pwm_multi #(
  parameter int NUM_CH    = 4,
  parameter int PRESCALE  = 1024,
  parameter int LEN_WIDTH = 11,
  parameter int PRE_WIDTH = $clog2(PRESCALE + 1),
  parameter int CH_WIDTH  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          cfg_valid,
  output logic                          cfg_ready,
  input  logic [CH_WIDTH-1:0]           cfg_ch,
  input  logic [LEN_WIDTH-1:0]          cfg_period,
  input  logic [LEN_WIDTH-1:0]          cfg_duty,
  input  logic                          cfg_active_high,
  input  logic                          cfg_center,
  input  logic                          sync,
  input  logic [NUM_CH-1:0]             enable,
  output logic [NUM_CH-1:0]             pending,
  output logic [NUM_CH*LEN_WIDTH-1:0]   period_out,
  output logic [NUM_CH*LEN_WIDTH-1:0]   duty_out,
  output logic [NUM_CH-1:0]             period_end,
  output logic [NUM_CH-1:0]             pwm_out
);

  localparam logic [LEN_WIDTH-1:0] ONE = LEN_WIDTH'(1);
  localparam logic [LEN_WIDTH-1:0] TWO = LEN_WIDTH'(2);
  localparam logic [PRE_WIDTH-1:0] PRE_LAST = PRE_WIDTH'(PRESCALE - 1);

  logic [PRE_WIDTH-1:0] pre_q, pre_d;
  logic                 tick;
  logic                 ctr_wdat;

  assign cfg_ready = !reset;

  // Center mode is only honoured when the feature is built in; otherwise the
  // written center bit is forced to 0 so every channel stays edge-aligned.
`ifdef MAWG_PWM_CENTER_EN
  assign ctr_wdat = cfg_center;
`else
  logic unused_cfg_center;
  assign unused_cfg_center = cfg_center;
  assign ctr_wdat = 1'b0;
`endif

  // Prescaler next value: restart on sync, otherwise count 0..PRESCALE-1 and wrap.
  always_comb begin
    pre_d = pre_q + PRE_WIDTH'(1);
    if (sync || (pre_q >= PRE_LAST)) pre_d = '0;
  end

  // Prescaler register.
  always_ff @(posedge clk) begin
    if (reset) pre_q <= '0;
    else       pre_q <= pre_d;
  end

  // sync wins over tick so the cycle after sync is the first aligned tick.
  assign tick = (pre_q == '0) && !sync;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [LEN_WIDTH-1:0] cnt_q, cnt_d, cnt_nxt;
    logic [LEN_WIDTH-1:0] per_q, per_d, duty_q, duty_d;
    logic [LEN_WIDTH-1:0] sh_per_q, sh_per_d, sh_duty_q, sh_duty_d;
    logic                 ah_q, ah_d, sh_ah_q, sh_ah_d;
    logic                 ctr_q, ctr_d, sh_ctr_q, sh_ctr_d;
    logic                 dir_q, dir_d, dir_nxt;  // 0 = counting up, 1 = counting down
    logic                 pend_q, pend_d, pwm_q, pwm_d, pe_q, pe_d;
    logic                 wr, per_zero, run, wrap, apply;

    assign wr       = cfg_valid && cfg_ready && (cfg_ch == CH_WIDTH'(g));
    assign per_zero = (per_q == '0);
    assign run      = tick && enable[g] && !per_zero;
    // A pending config lands at the boundary, or at once when the channel is idle/restarting.
    assign apply    = sync || !enable[g] || per_zero || (run && wrap);

    // Counter step: sawtooth 0..P-1, or triangle 0..P-1..1 in center mode; wrap marks the boundary.
    always_comb begin
      cnt_nxt = cnt_q + ONE;
      dir_nxt = 1'b0;
      wrap    = (cnt_q >= per_q - ONE);
      if (wrap) cnt_nxt = '0;
      if (ctr_q) begin
        if (per_q == ONE) begin
          cnt_nxt = '0;
          wrap    = 1'b1;
          dir_nxt = 1'b0;
        end else if (!dir_q) begin
          if (cnt_q >= per_q - ONE) begin
            cnt_nxt = per_q - TWO;
            wrap    = (per_q == TWO);
            dir_nxt = (per_q != TWO);
          end else begin
            cnt_nxt = cnt_q + ONE;
            wrap    = 1'b0;
            dir_nxt = 1'b0;
          end
        end else begin
          if (cnt_q <= ONE) begin
            cnt_nxt = '0;
            wrap    = 1'b1;
            dir_nxt = 1'b0;
          end else begin
            cnt_nxt = cnt_q - ONE;
            wrap    = 1'b0;
            dir_nxt = 1'b1;
          end
        end
      end
    end

    // Shadow/active config, pending flag, counter and output next state.
    always_comb begin
      sh_per_d  = sh_per_q;
      sh_duty_d = sh_duty_q;
      sh_ah_d   = sh_ah_q;
      sh_ctr_d  = sh_ctr_q;
      if (wr) begin
        sh_per_d  = cfg_period;
        sh_duty_d = cfg_duty;
        sh_ah_d   = cfg_active_high;
        sh_ctr_d  = ctr_wdat;
      end
      per_d  = per_q;
      duty_d = duty_q;
      ah_d   = ah_q;
      ctr_d  = ctr_q;
      pend_d = pend_q;
      if (apply) begin
        per_d  = sh_per_d;
        duty_d = sh_duty_d;
        ah_d   = sh_ah_d;
        ctr_d  = sh_ctr_d;
        pend_d = 1'b0;
      end else if (wr) begin
        pend_d = 1'b1;
      end
      pwm_d = pwm_q;
      pe_d  = 1'b0;
      cnt_d = cnt_q;
      dir_d = dir_q;
      if (!enable[g] || per_zero) begin
        // Idle level follows the polarity that will be active after this edge.
        pwm_d = !ah_d;
        cnt_d = '0;
        dir_d = 1'b0;
      end else if (sync) begin
        cnt_d = '0;
        dir_d = 1'b0;
      end else if (run) begin
        pwm_d = (cnt_q < duty_q) ? ah_q : !ah_q;
        pe_d  = wrap;
        cnt_d = cnt_nxt;
        dir_d = dir_nxt;
      end
    end

    // Per-channel state registers.
    always_ff @(posedge clk) begin
      if (reset) begin
        cnt_q     <= '0;
        per_q     <= '0;
        duty_q    <= '0;
        sh_per_q  <= '0;
        sh_duty_q <= '0;
        ah_q      <= 1'b1;
        sh_ah_q   <= 1'b1;
        ctr_q     <= 1'b0;
        sh_ctr_q  <= 1'b0;
        dir_q     <= 1'b0;
        pend_q    <= 1'b0;
        pwm_q     <= 1'b0;
        pe_q      <= 1'b0;
      end else begin
        cnt_q     <= cnt_d;
        per_q     <= per_d;
        duty_q    <= duty_d;
        sh_per_q  <= sh_per_d;
        sh_duty_q <= sh_duty_d;
        ah_q      <= ah_d;
        sh_ah_q   <= sh_ah_d;
        ctr_q     <= ctr_d;
        sh_ctr_q  <= sh_ctr_d;
        dir_q     <= dir_d;
        pend_q    <= pend_d;
        pwm_q     <= pwm_d;
        pe_q      <= pe_d;
      end
    end

    assign pending[g]                             = pend_q;
    assign period_end[g]                          = pe_q;
    assign pwm_out[g]                             = pwm_q;
    assign period_out[g*LEN_WIDTH +: LEN_WIDTH]   = per_q;
    assign duty_out[g*LEN_WIDTH +: LEN_WIDTH]     = duty_q;
  end

endmodule

// File: tb/tb_pwm_multi.sv
// Bench for pwm_multi: step-position model checked every cycle plus literal pattern checks.
module tb_pwm_multi;
  localparam int NCH = 4;
  localparam int PS  = 2;
  localparam int LW  = 8;
`ifdef MAWG_PWM_CENTER_EN
  localparam bit CTR_ON = 1'b1;
`else
  localparam bit CTR_ON = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            cfg_valid = 1'b0;
  logic            cfg_ready;
  logic [1:0]      cfg_ch = '0;
  logic [LW-1:0]   cfg_period = '0;
  logic [LW-1:0]   cfg_duty = '0;
  logic            cfg_active_high = 1'b1;
  logic            cfg_center = 1'b0;
  logic            sync = 1'b0;
  logic [NCH-1:0]  enable = '0;
  logic [NCH-1:0]  pending, period_end, pwm_out;
  logic [NCH*LW-1:0] period_out, duty_out;

  int checks = 0;
  int failures = 0;

  pwm_multi #(.NUM_CH(NCH), .PRESCALE(PS), .LEN_WIDTH(LW)) dut (
    .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_period(cfg_period), .cfg_duty(cfg_duty),
    .cfg_active_high(cfg_active_high), .cfg_center(cfg_center), .sync(sync),
    .enable(enable), .pending(pending), .period_out(period_out), .duty_out(duty_out),
    .period_end(period_end), .pwm_out(pwm_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Each channel keeps its position k within the period; the counter value is
  // derived from k (sawtooth k, or triangle for center mode).
  int m_pre;
  bit m_valid = 1'b0;
  int m_k[NCH], m_per[NCH], m_duty[NCH], s_per[NCH], s_duty[NCH];
  bit m_ah[NCH], s_ah[NCH], m_ctr[NCH], s_ctr[NCH], m_pend[NCH], m_pwm[NCH], m_pe[NCH];

  function automatic int per_len(input int p, input bit c);
    if (!c) return p;
    if (p <= 1) return 1;
    return 2 * (p - 1);
  endfunction

  function automatic int pos_cnt(input int k, input int p, input bit c);
    if (!c || k < p) return k;
    return 2 * (p - 1) - k;
  endfunction

  always @(posedge clk) begin
    bit tick, run, wrap, apply, wr, old_ah;
    int old_p;
    if (reset) begin
      m_valid = 1'b1;
      m_pre = 0;
      for (int i = 0; i < NCH; i++) begin
        m_k[i] = 0; m_per[i] = 0; m_duty[i] = 0; s_per[i] = 0; s_duty[i] = 0;
        m_ah[i] = 1'b1; s_ah[i] = 1'b1; m_ctr[i] = 1'b0; s_ctr[i] = 1'b0;
        m_pend[i] = 1'b0; m_pwm[i] = 1'b0; m_pe[i] = 1'b0;
      end
    end else if (m_valid) begin
      tick  = (m_pre == 0) && !sync;
      m_pre = sync ? 0 : (m_pre + 1) % PS;
      for (int i = 0; i < NCH; i++) begin
        wr = cfg_valid && (int'(cfg_ch) == i);
        if (wr) begin
          s_per[i] = int'(cfg_period); s_duty[i] = int'(cfg_duty);
          s_ah[i] = cfg_active_high; s_ctr[i] = CTR_ON && cfg_center;
        end
        old_p  = m_per[i];
        old_ah = m_ah[i];
        run    = tick && enable[i] && (old_p != 0);
        wrap   = run && (m_k[i] + 1 >= per_len(old_p, m_ctr[i]));
        apply  = sync || !enable[i] || (old_p == 0) || wrap;
        if (run) begin
          m_pwm[i] = (pos_cnt(m_k[i], old_p, m_ctr[i]) < m_duty[i]) ? old_ah : !old_ah;
          m_k[i]   = wrap ? 0 : m_k[i] + 1;
        end
        m_pe[i] = wrap;
        if (apply) begin
          m_per[i] = s_per[i]; m_duty[i] = s_duty[i]; m_ah[i] = s_ah[i]; m_ctr[i] = s_ctr[i];
          m_pend[i] = 1'b0;
        end else if (wr) begin
          m_pend[i] = 1'b1;
        end
        if (!enable[i] || old_p == 0) begin
          m_pwm[i] = !m_ah[i];
          m_k[i] = 0;
        end
        if (sync) m_k[i] = 0;
      end
    end
  end

  // Compare every cycle once the model has seen reset.
  always @(negedge clk) begin
    logic [NCH-1:0]    e_pwm, e_pe, e_pend;
    logic [NCH*LW-1:0] e_per, e_duty;
    if (m_valid) begin
      for (int i = 0; i < NCH; i++) begin
        e_pwm[i] = m_pwm[i];
        e_pe[i]  = m_pe[i];
        e_pend[i] = m_pend[i];
        e_per[i*LW +: LW]  = LW'(m_per[i]);
        e_duty[i*LW +: LW] = LW'(m_duty[i]);
      end
      chk("model_pwm_out", 64'(pwm_out), 64'(e_pwm));
      chk("model_period_end", 64'(period_end), 64'(e_pe));
      chk("model_pending", 64'(pending), 64'(e_pend));
      chk("model_period_out", 64'(period_out), 64'(e_per));
      chk("model_duty_out", 64'(duty_out), 64'(e_duty));
      chk("model_cfg_ready", 64'(cfg_ready), 64'(!reset));
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr_cfg(input int ch, input int p, input int d, input bit ah, input bit ctr);
    cfg_valid = 1'b1;
    cfg_ch = 2'(ch);
    cfg_period = LW'(p);
    cfg_duty = LW'(d);
    cfg_active_high = ah;
    cfg_center = ctr;
    cyc(1);
    cfg_valid = 1'b0;
  endtask

  task automatic count_win(input int ch, input int n, output int hi, output int pe);
    hi = 0;
    pe = 0;
    repeat (n) begin
      cyc(1);
      hi += int'(pwm_out[ch]);
      pe += int'(period_end[ch]);
    end
  endtask

  task automatic wait_pe(input int ch, input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      cyc(1);
      if (period_end[ch]) seen = 1'b1;
    end
  endtask

  initial begin
    int hi, pe, diff;
    bit seen;
    // Reset values
    cyc(3);
    chk("rst_pwm_out", 64'(pwm_out), 64'h0);
    chk("rst_pending", 64'(pending), 64'h0);
    chk("rst_period_end", 64'(period_end), 64'h0);
    chk("rst_cfg_ready", 64'(cfg_ready), 64'h0);
    chk("rst_period_out", 64'(period_out), 64'h0);
    reset = 1'b0;

    // 1: ch0 P=4 D=1 -> 2 of 8 clk high, one period_end per 8 clk
    wr_cfg(0, 4, 1, 1'b1, 1'b0);
    chk("t1_applied_idle", 64'(period_out[LW-1:0]), 64'd4);
    enable = 4'b0001;
    cyc(5);
    count_win(0, 16, hi, pe);
    chk("t1_high_clks", 64'(hi), 64'd4);
    chk("t1_period_ends", 64'(pe), 64'd2);

    // 2: ch1 P=10 D=5, mid-period rewrite (last wins) to D=2
    wr_cfg(1, 10, 5, 1'b1, 1'b0);
    enable = 4'b0011;
    wait_pe(1, 60, seen);
    chk("t2_first_wrap_seen", 64'(seen), 64'd1);
    cyc(6);
    wr_cfg(1, 10, 7, 1'b1, 1'b0);
    wr_cfg(1, 10, 2, 1'b1, 1'b0);
    chk("t2_pending_set", 64'(pending[1]), 64'd1);
    chk("t2_duty_unchanged", 64'(duty_out[LW +: LW]), 64'd5);
    wait_pe(1, 40, seen);
    chk("t2_wrap_seen", 64'(seen), 64'd1);
    chk("t2_pending_clear", 64'(pending[1]), 64'd0);
    chk("t2_duty_applied", 64'(duty_out[LW +: LW]), 64'd2);
    count_win(1, 20, hi, pe);
    chk("t2_high_clks", 64'(hi), 64'd4);

    // 3: D=0 inactive, D>=P active, P=0 inactive
    wr_cfg(3, 10, 0, 1'b1, 1'b0);
    enable = 4'b1011;
    cyc(4);
    count_win(3, 20, hi, pe);
    chk("t3_duty0_high", 64'(hi), 64'd0);
    wr_cfg(3, 10, 12, 1'b1, 1'b0);
    cyc(24);
    count_win(3, 40, hi, pe);
    chk("t3_dutybig_high", 64'(hi), 64'd40);
    wr_cfg(3, 0, 5, 1'b1, 1'b0);
    cyc(24);
    count_win(3, 20, hi, pe);
    chk("t3_p0_high", 64'(hi), 64'd0);
    chk("t3_p0_pe", 64'(pe), 64'd0);

    // 4: ch2 started later than ch0, sync realigns them
    wr_cfg(2, 4, 1, 1'b1, 1'b0);
    cyc(3);
    enable = 4'b1111;
    cyc(5);
    sync = 1'b1;
    cyc(1);
    sync = 1'b0;
    diff = 0;
    hi = 0;
    repeat (24) begin
      cyc(1);
      if (pwm_out[0] !== pwm_out[2]) diff++;
      hi += int'(pwm_out[0]);
    end
    chk("t4_ch0_ch2_differ", 64'(diff), 64'd0);
    chk("t4_ch0_high", 64'(hi), 64'd6);

    // 5: active-low idle level, then reset mid-period
    wr_cfg(2, 4, 1, 1'b0, 1'b0);
    cyc(2);
    enable = 4'b1011;
    cyc(2);
    chk("t5_idle_high", 64'(pwm_out[2]), 64'd1);
    chk("t5_pending2", 64'(pending[2]), 64'd0);
    wr_cfg(1, 10, 3, 1'b1, 1'b0);
    reset = 1'b1;
    cyc(1);
    chk("t5_rst_pwm", 64'(pwm_out), 64'h0);
    chk("t5_rst_pending", 64'(pending), 64'h0);
    chk("t5_rst_ready", 64'(cfg_ready), 64'h0);
    chk("t5_rst_duty", 64'(duty_out), 64'h0);
    enable = 4'b0000;
    cyc(2);
    reset = 1'b0;

    // 6: center request on P=5 D=2
    wr_cfg(0, 5, 2, 1'b1, 1'b1);
    enable = 4'b0001;
    cyc(3);
`ifdef MAWG_PWM_CENTER_EN
    count_win(0, 32, hi, pe);
    chk("t6_center_high", 64'(hi), 64'd12);
    chk("t6_center_pe", 64'(pe), 64'd2);
`else
    count_win(0, 30, hi, pe);
    chk("t6_edge_high", 64'(hi), 64'd12);
    chk("t6_edge_pe", 64'(pe), 64'd3);
`endif

    cyc(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
